// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and parameter helpers for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 32'sd0) ? (width / chunk) : 32'sd1;
    endfunction

    function automatic bit params_legal(input int width, input int chunk);
        return (chunk >= 32'sd1) && (chunk <= width) && ((width % chunk) == 32'sd0);
    endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk.sv
// CHUNK-bit ripple-carry adder; c_msb is the carry into the top bit for overflow detection.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic ripple_s;

    // Bit-serial ripple across the chunk
    always_comb begin
        sum      = {CHUNK{1'b0}};
        ripple_s = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ ripple_s;
            ripple_s = (a[i] & b[i]) | (ripple_s & (a[i] ^ b[i]));
        end
        cout  = ripple_s;
        c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock behind valid/ready handshakes.
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
        $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_out_r;
    logic              overflow_r;
    logic              in_ready_r;
    logic              out_valid_r;

    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK-1:0]  chunk_sum_s;
    logic              chunk_cout_s;
    logic              chunk_cmsb_s;

    assign a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
    assign b_chunk_s = b_r[idx_r*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk_s),
        .b     (b_chunk_s),
        .cin   (carry_r),
        .sum   (chunk_sum_s),
        .cout  (chunk_cout_s),
        .c_msb (chunk_cmsb_s)
    );

    // Control FSM and datapath registers; in_ready is held low for one cycle after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDXW{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_ready_r && in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        carry_r    <= cin;
                        idx_r      <= {IDXW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[idx_r*CHUNK +: CHUNK] <= chunk_sum_s;
                    carry_r <= chunk_cout_s;
                    if (idx_r == IDXW'(NCHUNK - 1)) begin
                        carry_out_r <= chunk_cout_s;
                        overflow_r  <= chunk_cout_s ^ chunk_cmsb_s;
                        idx_r       <= {IDXW{1'b0}};
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry     = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench: three adder configurations against a plain-arithmetic reference model.
module tb_chunked_seq_adder;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W  = (g == 1) ? 4 : ((g == 2) ? 32 : 16);
        localparam int C  = (g == 2) ? 8 : 4;
        localparam int NC = W / C;

        logic         rst = 1'b1;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         cin = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b0;
        logic [W-1:0] sum;
        logic         carry;
        logic         overflow;
        bit           want_rdy = 1'b0;
        bit           rand_rdy = 1'b0;
        bit           done = 1'b0;
        logic [W:0]   exp_q[$];
        bit           ovf_q[$];
        int           cyc = 0;
        int           acc_cyc = 0;
        bit           seen = 1'b0;

        chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
            .sum(sum), .carry(carry), .overflow(overflow)
        );

        function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
            return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        endfunction

        // signed overflow: operands share a sign that the result does not
        function automatic bit ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
            return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        endfunction

        task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s (W=%0d C=%0d): got %0h expected %0h", name, W, C, act, exp);
            end
        endtask

        always @(posedge clk) cyc <= cyc + 1;

        initial forever begin
            @(posedge clk);
            #2;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : want_rdy;
        end

        // compare process: every cycle against the reference queue
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                ovf_q.delete();
                seen = 1'b0;
                chk("reset_outputs", {sum, carry, overflow, out_valid, in_ready}, 64'd0);
            end else begin
                if (out_valid) begin
                    chk("in_ready_while_valid", in_ready, 64'd0);
                    chk("valid_with_op_pending", exp_q.size(), 64'd1);
                    if (exp_q.size() != 0) begin
                        if (!seen) begin
                            chk("latency", cyc - acc_cyc, NC);
                            seen = 1'b1;
                        end
                        chk("sum", sum, exp_q[0][W-1:0]);
                        chk("carry", carry, exp_q[0][W]);
                        chk("overflow", overflow, ovf_q[0]);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(ovf_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    chk("in_ready_while_busy", in_ready, 64'd0);
                    if (cyc - acc_cyc == NC + 1) chk("valid_late", cyc - acc_cyc, NC);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_add(a, b, cin));
                    ovf_q.push_back(ref_ovf(a, b, W'(ref_add(a, b, cin))));
                    acc_cyc = cyc + 1;
                end
            end
        end

        // called at posedge+1; returns at accept edge+1 with operands scrambled
        task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
            int n = 0;
            a = x; b = y; cin = ci; in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("accept_wait", (n < 100), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        endtask

        task automatic wait_valid(output int n);
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("valid_wait", out_valid, 64'd1);
        endtask

        task automatic release_out();
            @(posedge clk); #1; want_rdy = 1'b1;
            @(posedge clk); #1; want_rdy = 1'b0;
        endtask

        task automatic reset_seq();
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("ready_after_reset", in_ready, 64'd1);
            @(posedge clk);
            #1;
        endtask

        task automatic rand_ops(input int n_ops);
            logic [W-1:0] x;
            logic [W-1:0] y;
            int k = 0;
            rand_rdy = 1'b1;
            for (int i = 0; i < n_ops; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                x = W'($urandom);
                y = W'($urandom);
                if (i % 10 == 0) x = '1;
                if (i % 10 == 5) y = {1'b0, {(W-1){1'b1}}};
                send(x, y, 1'($urandom));
            end
            while (exp_q.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("drain", exp_q.size(), 64'd0);
            rand_rdy = 1'b0;
        endtask

        if (g == 0) begin : dir
            initial begin
                int n;
                reset_seq();
                send(16'h0000, 16'h0005, 1'b0);
                wait_valid(n);
                chk("small_latency", n, 64'd4);
                chk("small_sum", {carry, overflow, sum}, {2'b00, 16'h0005});
                release_out();

                send(16'hFFFF, 16'hFFFF, 1'b1);
                wait_valid(n);
                chk("ripple_ffff", {carry, overflow, sum}, {2'b10, 16'hFFFF});
                release_out();

                send(16'h7FFF, 16'h0001, 1'b0);
                wait_valid(n);
                chk("ripple_7fff", {carry, overflow, sum}, {2'b01, 16'h8000});
                release_out();

                send(16'h1111, 16'h2222, 1'b0);
                wait_valid(n);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
                    @(negedge clk);
                    chk("bp_sum_held", sum, 64'h3333);
                    chk("bp_in_ready", in_ready, 64'd0);
                end
                release_out();
                @(negedge clk);
                chk("ready_after_handshake", in_ready, 64'd1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                wait_valid(n);
                chk("bp_next_latency", n, 64'd4);
                chk("bp_next_sum", {carry, overflow, sum}, {2'b10, 16'h0000});
                release_out();

                send(16'h1234, 16'h4321, 1'b0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                chk("midrun_reset", {sum, carry, overflow, out_valid, in_ready}, 64'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("ready_after_midrun_reset", in_ready, 64'd1);
                @(posedge clk); #1;
                send(16'h0006, 16'h000F, 1'b0);
                wait_valid(n);
                chk("after_reset_sum", {carry, overflow, sum}, {2'b00, 16'h0015});
                release_out();

                rand_ops(200);
                done = 1'b1;
            end
        end else begin : rnd
            initial begin
                reset_seq();
                rand_ops(500);
                done = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (u[0].done && u[1].done && u[2].done);
            begin
                #600000;
                failures++;
                $display("FAIL global_timeout: elapsed 600000ns, required all instances done");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
